uart_multibyte_receiver: RTL and testbench
==========================================

// Module: uart_multibyte_receiver
// PURPOSE
// - Receive-side counterpart of uart_multibyte_transmitter: 8N1 UART deserializer that packs 2**MSG_LOG_WIDTH bytes into one wide word.
// - First byte received lands in data[7:0]; delivers the word with a single-cycle valid pulse.
// - Sits behind the top-level two-flop RsRx synchronizer; uart_rx is already synchronous to clk.
// PARAMETERS
// - CLK_CYCLES      87      clk cycles per bit (10MHz / 115200)
// - MSG_LOG_WIDTH   4       log2 of bytes per message (4 -> 16 bytes, 128-bit data)
// - TIMEOUT_CYCLES  100000  idle cycles before a partial message is dropped (UART_MBRX_TIMEOUT_EN only)
// PORTS
// - clk        in   1                      single system clock, all logic on posedge
// - rst        in   1                      synchronous, active-high reset
// - uart_rx    in   1                      synchronized serial line, idle high
// - data       out  8*2**MSG_LOG_WIDTH     last complete message; byte k at [8k+7:8k]
// - valid      out  1                      1-cycle pulse: data just updated
// - frame_err  out  1                      1-cycle pulse: stop bit sampled low
// - busy       out  1                      high while a frame is in progress or a partial message is held
// BEHAVIOUR
// - Reset: data=0, valid=0, frame_err=0, busy=0, FSM=IDLE, byte index=0, all counters=0.
// - Bit FSM: IDLE -> START -> DATA -> STOP -> IDLE (or WAIT_HIGH).
//   - IDLE: uart_rx==0 -> START, load bit counter with CLK_CYCLES/2 (integer division).
//   - START: at counter expiry re-sample; 0 -> DATA with counter=CLK_CYCLES; 1 -> IDLE (glitch, nothing reported).
//   - DATA: sample every CLK_CYCLES; 8 samples shifted in LSB first; after 8th -> STOP.
//   - STOP: sample after CLK_CYCLES. 1 -> accept byte, go IDLE immediately (mid-stop-bit, so back-to-back frames work).
//     0 -> frame_err pulse next cycle; byte discarded; byte index=0 (partial message dropped); -> WAIT_HIGH.
//   - WAIT_HIGH: stay until uart_rx==1, then IDLE.
// - Assembly: accepted byte written to slot [byte index] of an internal buffer; index increments, wraps 2**MSG_LOG_WIDTH-1 -> 0.
// - Completion: when the last slot is written, data <= full buffer; valid=1 in the cycle after the stop sample.
//   - data holds until the next completion; never changes mid-message.
// - Latency: valid rises 1 clk after the mid-stop-bit sample of the final byte.
// - busy = (FSM != IDLE) || (byte index != 0).
// - valid and frame_err are mutually exclusive; each lasts exactly one cycle.
// - rst mid-frame: abort frame and message, outputs to reset values, next falling edge treated as a new start.
// - Counters are sized to hold CLK_CYCLES and TIMEOUT_CYCLES; no arithmetic overflow permitted.
// CONFIGURATION
// - UART_MBRX_TIMEOUT_EN defined:
//   - idle counter runs while FSM==IDLE and byte index!=0; cleared on any start;
//   - reaching TIMEOUT_CYCLES resets byte index to 0 silently (no valid, no frame_err); data unchanged.
// - Undefined: no idle counter; a partial message is held indefinitely and completed by later bytes.
// TESTING
// - Send "hello world-----" (16 bytes, 87 cyc/bit, back-to-back)
//   -> exactly one valid; data==128'h2d2d2d2d2d646c726f77206f6c6c6568.
// - Pull uart_rx low 20 cycles then high; then send 16 bytes
//   -> no byte counted from glitch, frame_err never pulses, single valid with correct data.
// - 3 good bytes, then 0x41 with stop bit low, then 16 bytes 0x00..0x0F
//   -> one frame_err pulse; valid once; data byte k==k.
// - rst asserted 1 cycle during DATA of byte 7
//   -> outputs all 0 next cycle; then 16 fresh bytes yield one valid with those bytes only.
// - 5 bytes 0xAA, idle > TIMEOUT_CYCLES, then 16 bytes 0x55
//   -> with UART_MBRX_TIMEOUT_EN: data all 0x55, busy drops during the idle gap;
//   -> without UART_MBRX_TIMEOUT_EN: data bytes 0-4==0xAA, bytes 5-15==0x55.
// - 32 bytes back-to-back -> two valid pulses 160 bit-times apart; second word is bytes 16-31.

Source files
------------

// File: rtl/uart_multibyte_receiver.sv
// 8N1 UART receiver packing 2**MSG_LOG_WIDTH bytes into one word, first byte in data[7:0].
// Define UART_MBRX_TIMEOUT_EN to drop partial messages after TIMEOUT_CYCLES idle cycles.
module uart_multibyte_receiver #(
  parameter int CLK_CYCLES     = 87,
  parameter int MSG_LOG_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  output logic [8*(2**MSG_LOG_WIDTH)-1:0] data,
  output logic                          valid,
  output logic                          frame_err,
  output logic                          busy
);

  localparam int NB = 2**MSG_LOG_WIDTH;
  localparam int W  = 8*NB;
  localparam int CW = $clog2(CLK_CYCLES+1);
  localparam int IW = (MSG_LOG_WIDTH > 0) ? MSG_LOG_WIDTH : 1;

  localparam logic [CW-1:0] HALF = CW'(CLK_CYCLES/2);
  localparam logic [CW-1:0] FULL = CW'(CLK_CYCLES);
  localparam logic [IW-1:0] LAST = IW'(NB-1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [IW-1:0] idx;
  logic [W-1:0]  msg_buf;
  logic [W-1:0]  msg_next;

`ifdef UART_MBRX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] idle_cnt;
`endif

  always_comb begin
    msg_next = msg_buf;
    msg_next[{idx, 3'b000} +: 8] = shreg;
  end

  assign busy = (state != IDLE) || (idx != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      idx       <= '0;
      msg_buf   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_MBRX_TIMEOUT_EN
      idle_cnt  <= '0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_MBRX_TIMEOUT_EN
      // Idle time only accrues while a partial message waits on a quiet line
      if (state == IDLE && idx != '0 && uart_rx) begin
        if (idle_cnt == TW'(TIMEOUT_CYCLES-1)) begin
          idx      <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
`endif
      unique case (state)
        IDLE: begin
          if (!uart_rx) begin
            state <= START;
            cnt   <= HALF;
          end
        end
        START: begin
          if (cnt <= 1) begin
            if (!uart_rx) begin
              state   <= DATA;
              cnt     <= FULL;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt <= 1) begin
            shreg   <= {uart_rx, shreg[7:1]};
            cnt     <= FULL;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt <= 1) begin
            if (uart_rx) begin
              msg_buf <= msg_next;
              state   <= IDLE;
              if (idx == LAST) begin
                idx   <= '0;
                data  <= msg_next;
                valid <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              idx       <= '0;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (uart_rx) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_multibyte_receiver.sv
// Directed bench for uart_multibyte_receiver: 87 clk/bit frames, hand-computed words.
// Honours UART_MBRX_TIMEOUT_EN for the idle-gap expectations.
module tb_uart_multibyte_receiver;

  localparam int CC = 87;

  logic         clk = 1'b0;
  logic         rst;
  logic         uart_rx;
  logic [127:0] data;
  logic         valid;
  logic         frame_err;
  logic         busy;

  int total = 0;
  int bad   = 0;

  int           cyc = 0;
  int           fe_cnt = 0;
  int           both = 0;
  logic [127:0] vq[$];
  int           vt[$];

  uart_multibyte_receiver #(
    .CLK_CYCLES(CC),
    .MSG_LOG_WIDTH(4),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .uart_rx(uart_rx),
    .data(data),
    .valid(valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (valid) begin
      vq.push_back(data);
      vt.push_back(cyc);
    end
    if (frame_err) fe_cnt++;
    if (valid && frame_err) both++;
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0, CC);
    for (int i = 0; i < 8; i++) send_bit(b[i], CC);
    send_bit(stop_bit, CC);
  endtask

  initial begin
    string s;
    int v0;
    int f0;
    logic [127:0] w;

    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", data, '0);
    chk("rst_valid", 128'(valid), 0);
    chk("rst_ferr", 128'(frame_err), 0);
    chk("rst_busy", 128'(busy), 0);
    rst = 1'b0;
    send_bit(1'b1, 50);

    // 32 bytes back to back: two words
    s = "hello world-----";
    v0 = vq.size();
    f0 = fe_cnt;
    for (int i = 0; i < 16; i++) send_byte(s[i], 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'hF0 - 8'(i), 1'b1);
    send_bit(1'b1, 100);
    chk("b2b_vcnt", 128'(vq.size() - v0), 2);
    if (vq.size() >= v0 + 2) begin
      chk("hello_word", vq[v0], 128'h2d2d2d2d2d646c726f77206f6c6c6568);
      chk("word2", vq[v0+1], 128'he1e2e3e4e5e6e7e8e9eaebecedeeeff0);
      chk("spacing", 128'(vt[v0+1] - vt[v0]), 160*CC);
    end
    chk("b2b_ferr", 128'(fe_cnt - f0), 0);

    // frame error drops the partial message
    v0 = vq.size();
    f0 = fe_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h41, 1'b0);
    send_bit(1'b1, 2*CC);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    send_bit(1'b1, 100);
    chk("err_ferr", 128'(fe_cnt - f0), 1);
    chk("err_vcnt", 128'(vq.size() - v0), 1);
    chk("err_data", data, 128'h0f0e0d0c0b0a09080706050403020100);

    // reset in the middle of byte 7
    for (int i = 0; i < 7; i++) send_byte(8'h99, 1'b1);
    send_bit(1'b0, CC);
    send_bit(1'b1, CC);
    send_bit(1'b0, 40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    uart_rx = 1'b1;
    chk("mid_rst_data", data, '0);
    chk("mid_rst_valid", 128'(valid), 0);
    chk("mid_rst_ferr", 128'(frame_err), 0);
    chk("mid_rst_busy", 128'(busy), 0);
    send_bit(1'b1, 300);
    v0 = vq.size();
    for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i), 1'b1);
    send_bit(1'b1, 100);
    chk("post_rst_vcnt", 128'(vq.size() - v0), 1);
    chk("post_rst_data", data, 128'h3f3e3d3c3b3a39383736353433323130);

    // glitch, partial message, long idle gap
    f0 = fe_cnt;
    v0 = vq.size();
    send_bit(1'b0, 20);
    send_bit(1'b1, 200);
    chk("glitch_busy", 128'(busy), 0);
    for (int i = 0; i < 5; i++) send_byte(8'hAA, 1'b1);
    send_bit(1'b1, 1500);
`ifdef UART_MBRX_TIMEOUT_EN
    chk("gap_busy", 128'(busy), 0);
    w = 128'h55555555555555555555555555555555;
`else
    chk("gap_busy", 128'(busy), 1);
    w = 128'h5555555555555555555555aaaaaaaaaa;
`endif
    for (int i = 0; i < 16; i++) send_byte(8'h55, 1'b1);
    send_bit(1'b1, 100);
    chk("gap_vcnt", 128'(vq.size() - v0), 1);
    chk("gap_data", data, w);
    chk("gap_ferr", 128'(fe_cnt - f0), 0);
    chk("excl", 128'(both), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
